x_micro_sequencer_ctrl: RTL

- Host-side controller for the micro-sequencer. Takes a byte-stream command protocol (from the UART receiver), assembles 40-bit program words, and writes them into sequencer RAM.
- Issues start pulses and runs the loaded program N times back-to-back. Returns one response byte per command to the UART transmitter.
- Sits between the UART byte interfaces and the sequencer write/start/busy ports.

---
 rtl/x_micro_sequencer_ctrl.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/x_micro_sequencer_ctrl.sv
// Host-side micro-sequencer controller: decodes LOAD/RUN/STATUS byte commands, writes
// 40-bit program words into sequencer RAM and runs the loaded program N times.
module x_micro_sequencer_ctrl #(
  parameter int unsigned BUSY_TIMEOUT = 8,
  parameter logic [7:0]  ACK_BYTE     = 8'hA5,
  parameter logic [7:0]  ERR_BYTE     = 8'hEE
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_rx_valid,
  input  logic [7:0]  i_rx_data,
  output logic        o_rx_ready,
  output logic        o_tx_valid,
  output logic [7:0]  o_tx_data,
  input  logic        i_tx_ready,
  output logic        o_seq_wen,
  output logic [8:0]  o_seq_waddr,
  output logic [3:0]  o_seq_wcmd,
  output logic [35:0] o_seq_wdata,
  output logic        o_seq_start,
  input  logic        i_seq_busy,
  output logic [7:0]  o_runs
);

  localparam int unsigned TW = $clog2(BUSY_TIMEOUT + 1);

  localparam logic [3:0] IDLE      = 4'd0;
  localparam logic [3:0] ADDR      = 4'd1;
  localparam logic [3:0] WORD      = 4'd2;
  localparam logic [3:0] WRITE     = 4'd3;
  localparam logic [3:0] RUN_CNT   = 4'd4;
  localparam logic [3:0] START     = 4'd5;
  localparam logic [3:0] WAIT_BUSY = 4'd6;
  localparam logic [3:0] WAIT_DONE = 4'd7;
  localparam logic [3:0] GAP       = 4'd8;
  localparam logic [3:0] RESP      = 4'd9;

  logic [3:0]    state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [8:0]    addr_q, addr_d;
  logic [39:0]   word_q, word_d;
  logic [7:0]    runs_q, runs_d;
  logic [TW-1:0] tout_q, tout_d;
  logic          start_q, start_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          rx_accept;
  logic          run_active;

  // Ready is masked by reset so every output reads 0 while reset is held.
  assign o_rx_ready = !i_rst && (state_q == IDLE || state_q == ADDR ||
                                 state_q == WORD || state_q == RUN_CNT);
  assign rx_accept  = i_rx_valid && o_rx_ready;
  assign run_active = (state_q == START) || (state_q == WAIT_BUSY) ||
                      (state_q == WAIT_DONE) || (state_q == GAP);

  assign o_tx_valid  = (state_q == RESP);
  assign o_tx_data   = tx_data_q;
  assign o_seq_wen   = (state_q == WRITE);
  assign o_seq_waddr = addr_q;
  assign o_seq_wcmd  = word_q[3:0];
  assign o_seq_wdata = word_q[39:4];
  assign o_seq_start = start_q;
  assign o_runs      = runs_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    word_d    = word_q;
    runs_d    = runs_q;
    tout_d    = tout_q;
    start_d   = start_q;
    tx_data_d = tx_data_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = 3'd0;
        if (rx_accept) begin
          case (i_rx_data)
            8'h01: state_d = ADDR;
            8'h02: state_d = RUN_CNT;
            8'h03: begin
              tx_data_d = {6'b0, i_seq_busy, run_active};
              state_d   = RESP;
            end
            default: begin
              tx_data_d = ERR_BYTE;
              state_d   = RESP;
            end
          endcase
        end
      end
      ADDR: begin
        if (rx_accept) begin
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd0) begin
            addr_d[7:0] = i_rx_data;
          end else begin
            addr_d[8] = i_rx_data[0];
            state_d   = WORD;
          end
        end
      end
      WORD: begin
        // Bytes arrive LSB-first, so shift in from the top.
        if (rx_accept) begin
          word_d = {i_rx_data, word_q[39:8]};
          cnt_d  = cnt_q + 3'd1;
          if (cnt_q == 3'd6) state_d = WRITE;
        end
      end
      WRITE: begin
        tx_data_d = ACK_BYTE;
        state_d   = RESP;
      end
      RUN_CNT: begin
        if (rx_accept) begin
          runs_d  = (i_rx_data == 8'd0) ? 8'd1 : i_rx_data;
          state_d = START;
        end
      end
      START: begin
        start_d = 1'b1;
        tout_d  = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (i_seq_busy) begin
          start_d = 1'b0;
          state_d = WAIT_DONE;
        end else if (tout_q == TW'(BUSY_TIMEOUT - 1)) begin
          start_d   = 1'b0;
          runs_d    = 8'd0;
          tx_data_d = ERR_BYTE;
          state_d   = RESP;
        end else begin
          tout_d = tout_q + TW'(1);
        end
      end
      WAIT_DONE: begin
        if (!i_seq_busy) begin
          runs_d = runs_q - 8'd1;
          if (runs_q == 8'd1) begin
            tx_data_d = ACK_BYTE;
            state_d   = RESP;
          end else begin
            state_d = GAP;
          end
        end
      end
      GAP: state_d = START;
      RESP: begin
        if (i_tx_ready) begin
          tx_data_d = 8'd0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      cnt_q     <= 3'd0;
      addr_q    <= 9'd0;
      word_q    <= 40'd0;
      runs_q    <= 8'd0;
      tout_q    <= '0;
      start_q   <= 1'b0;
      tx_data_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      word_q    <= word_d;
      runs_q    <= runs_d;
      tout_q    <= tout_d;
      start_q   <= start_d;
      tx_data_q <= tx_data_d;
    end
  end

endmodule
